// File: rtl/wm8731_spi_rx_pkg.sv
// Shared constants for the WM8731 SPI receive model:
// register addresses, power-on defaults and FSM states.
package wm8731_pkg;

  localparam logic [6:0] R0 = 7'h00;
  localparam logic [6:0] R1 = 7'h01;
  localparam logic [6:0] R2 = 7'h02;
  localparam logic [6:0] R3 = 7'h03;
  localparam logic [6:0] R4 = 7'h04;
  localparam logic [6:0] R5 = 7'h05;
  localparam logic [6:0] R6 = 7'h06;
  localparam logic [6:0] R7 = 7'h07;
  localparam logic [6:0] R8 = 7'h08;
  localparam logic [6:0] R9 = 7'h09;
  localparam logic [6:0] REG_RESET = 7'h0F;

  localparam int REG_W = 9;

  // R9 in the top slice, R0 at [8:0]
  localparam logic [89:0] REG_DEFAULTS = {
    9'h000, 9'h000, 9'h00A, 9'h09F, 9'h008,
    9'h00A, 9'h079, 9'h079, 9'h097, 9'h097
  };

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    LATCH
  } state_t;

endpackage

// File: rtl/wm8731_spi_rx_spi_in_sync.sv
// One-bit SPI input conditioner: synchronizer, registered edge detect.
// WM8731_SPI_RX_DEGLITCH_EN adds a 3-sample majority filter.
module spi_in_sync #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk_50M,
  input  logic rst,
  input  logic i_async,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_sync;
  logic                   w_clean;
  logic                   r_prev;
  logic                   r_rise;
  logic                   r_fall;

  always_ff @(posedge clk_50M or posedge rst) begin
    if (rst) begin
      r_sync <= {SYNC_STAGES{RST_VAL}};
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
    end
  end

  assign w_sync = r_sync[SYNC_STAGES-1];

`ifdef WM8731_SPI_RX_DEGLITCH_EN
  logic [1:0] r_hist;
  logic       r_filt;

  always_ff @(posedge clk_50M or posedge rst) begin
    if (rst) begin
      r_hist <= {2{RST_VAL}};
      r_filt <= RST_VAL;
    end else begin
      r_hist <= {r_hist[0], w_sync};
      r_filt <= (w_sync & r_hist[0]) |
                (w_sync & r_hist[1]) |
                (r_hist[0] & r_hist[1]);
    end
  end

  assign w_clean = r_filt;
`else
  assign w_clean = w_sync;
`endif

  // level is delayed with the edges so data stays aligned to them
  always_ff @(posedge clk_50M or posedge rst) begin
    if (rst) begin
      r_prev <= RST_VAL;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_prev <= w_clean;
      r_rise <= w_clean & ~r_prev;
      r_fall <= ~w_clean & r_prev;
    end
  end

  assign o_level = r_prev;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;

endmodule

// File: rtl/wm8731_spi_rx.sv
// WM8731 3-wire SPI control responder with shadow register file.
// Optional WM8731_SPI_RX_DEGLITCH_EN filters sclk/csb glitches.
module wm8731_spi_rx
  import wm8731_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FRAME_BITS  = 16,
  parameter int NUM_REGS    = 10
) (
  input  logic                      clk_50M,
  input  logic                      rst,
  input  logic                      csb,
  input  logic                      sclk,
  input  logic                      sdin,
  output logic                      wr_strobe,
  output logic [6:0]                wr_addr,
  output logic [8:0]                wr_data,
  output logic                      frame_err,
  output logic                      addr_err,
  output logic [7:0]                frame_cnt,
  output logic [REG_W*NUM_REGS-1:0] regs_flat,
  output logic                      busy
);

  localparam logic [6:0] NREG7 = 7'(NUM_REGS);
  localparam logic [4:0] FBITS = 5'(FRAME_BITS);

  logic w_csb;
  logic w_csb_rise;
  logic w_csb_fall;
  logic w_sclk_rise;
  logic w_sdin;
  logic w_unused_sclk_lvl;
  logic w_unused_sclk_fall;
  logic w_unused_sdin_rise;
  logic w_unused_sdin_fall;

  spi_in_sync #(
    .SYNC_STAGES(SYNC_STAGES),
    .RST_VAL    (1'b1)
  ) u_csb (
    .clk_50M(clk_50M),
    .rst    (rst),
    .i_async(csb),
    .o_level(w_csb),
    .o_rise (w_csb_rise),
    .o_fall (w_csb_fall)
  );

  spi_in_sync #(
    .SYNC_STAGES(SYNC_STAGES),
    .RST_VAL    (1'b0)
  ) u_sclk (
    .clk_50M(clk_50M),
    .rst    (rst),
    .i_async(sclk),
    .o_level(w_unused_sclk_lvl),
    .o_rise (w_sclk_rise),
    .o_fall (w_unused_sclk_fall)
  );

  spi_in_sync #(
    .SYNC_STAGES(SYNC_STAGES),
    .RST_VAL    (1'b0)
  ) u_sdin (
    .clk_50M(clk_50M),
    .rst    (rst),
    .i_async(sdin),
    .o_level(w_sdin),
    .o_rise (w_unused_sdin_rise),
    .o_fall (w_unused_sdin_fall)
  );

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic                      w_start;
  logic                      r_pend;
  logic [FRAME_BITS-1:0]     r_sr;
  logic [4:0]                r_bit_cnt;
  logic [6:0]                w_addr;
  logic [8:0]                w_data;
  logic                      w_addr_ok;
  logic                      r_wr_strobe;
  logic [6:0]                r_wr_addr;
  logic [8:0]                r_wr_data;
  logic                      r_frame_err;
  logic                      r_addr_err;
  logic [7:0]                r_frame_cnt;
  logic [REG_W*NUM_REGS-1:0] r_regs;

  assign w_addr    = r_sr[FRAME_BITS-1 -: 7];
  assign w_data    = r_sr[8:0];
  assign w_addr_ok = (w_addr < NREG7);

  always_ff @(posedge clk_50M or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // a fall seen during LATCH is held in r_pend so IDLE still starts
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_csb_fall || r_pend) begin
          w_state_nxt = SHIFT;
          w_start     = 1'b1;
        end
      end
      SHIFT: begin
        if (w_csb_rise) begin
          w_state_nxt = LATCH;
        end
      end
      LATCH: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_50M or posedge rst) begin
    if (rst) begin
      r_pend    <= 1'b0;
      r_sr      <= '0;
      r_bit_cnt <= '0;
    end else begin
      if (r_state == LATCH && w_csb_fall) begin
        r_pend <= 1'b1;
      end else if (w_start) begin
        r_pend <= 1'b0;
      end
      if (w_start) begin
        r_sr      <= '0;
        r_bit_cnt <= '0;
      end else if (r_state == SHIFT && w_sclk_rise && !w_csb_rise) begin
        r_sr <= {r_sr[FRAME_BITS-2:0], w_sdin};
        if (r_bit_cnt != 5'd31) begin
          r_bit_cnt <= r_bit_cnt + 5'd1;
        end
      end
    end
  end

  always_ff @(posedge clk_50M or posedge rst) begin
    if (rst) begin
      r_wr_strobe <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_frame_err <= 1'b0;
      r_addr_err  <= 1'b0;
      r_frame_cnt <= '0;
      r_regs      <= REG_DEFAULTS[REG_W*NUM_REGS-1:0];
    end else begin
      r_wr_strobe <= 1'b0;
      r_frame_err <= 1'b0;
      r_addr_err  <= 1'b0;
      if (r_state == LATCH) begin
        if (r_bit_cnt != FBITS) begin
          r_frame_err <= 1'b1;
        end else if (w_addr_ok || w_addr == REG_RESET) begin
          r_wr_strobe <= 1'b1;
          r_wr_addr   <= w_addr;
          r_wr_data   <= w_data;
          r_frame_cnt <= r_frame_cnt + 8'd1;
          if (w_addr == REG_RESET) begin
            r_regs <= REG_DEFAULTS[REG_W*NUM_REGS-1:0];
          end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
              if (w_addr == 7'(i)) begin
                r_regs[i*REG_W +: REG_W] <= w_data;
              end
            end
          end
        end else begin
          r_addr_err <= 1'b1;
        end
      end
    end
  end

  assign wr_strobe = r_wr_strobe;
  assign wr_addr   = r_wr_addr;
  assign wr_data   = r_wr_data;
  assign frame_err = r_frame_err;
  assign addr_err  = r_addr_err;
  assign frame_cnt = r_frame_cnt;
  assign regs_flat = r_regs;
  assign busy      = ~w_csb;

endmodule

// File: tb/tb_wm8731_spi_rx.sv
// Directed testbench for wm8731_spi_rx: table of frames plus
// hand-written sequences for latency, edge races and reset.
module tb_wm8731_spi_rx;

  localparam int S    = 2;
  localparam int HALF = 6;
`ifdef WM8731_SPI_RX_DEGLITCH_EN
  localparam int LAT = S + 4;
  localparam int GAP = 2;
`else
  localparam int LAT = S + 2;
  localparam int GAP = 1;
`endif

  logic        clk_50M = 1'b0;
  logic        rst = 1'b1;
  logic        csb = 1'b1;
  logic        sclk = 1'b0;
  logic        sdin = 1'b0;
  logic        wr_strobe;
  logic [6:0]  wr_addr;
  logic [8:0]  wr_data;
  logic        frame_err;
  logic        addr_err;
  logic [7:0]  frame_cnt;
  logic [89:0] regs_flat;
  logic        busy;

  always #10 clk_50M = ~clk_50M;

  wm8731_spi_rx #(
    .SYNC_STAGES(S),
    .FRAME_BITS (16),
    .NUM_REGS   (10)
  ) dut (
    .clk_50M  (clk_50M),
    .rst      (rst),
    .csb      (csb),
    .sclk     (sclk),
    .sdin     (sdin),
    .wr_strobe(wr_strobe),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .frame_err(frame_err),
    .addr_err (addr_err),
    .frame_cnt(frame_cnt),
    .regs_flat(regs_flat),
    .busy     (busy)
  );

  int n_chk = 0;
  int n_fail = 0;
  int n_wr = 0;
  int n_fe = 0;
  int n_ae = 0;

  always @(negedge clk_50M) begin
    if (!rst) begin
      if (wr_strobe) n_wr++;
      if (frame_err) n_fe++;
      if (addr_err)  n_ae++;
    end
  end

  logic [8:0] DEF [10] = '{9'h097, 9'h097, 9'h079, 9'h079, 9'h00A,
                           9'h008, 9'h09F, 9'h00A, 9'h000, 9'h000};
  logic [8:0] INIT_EXP [10] = '{9'h017, 9'h017, 9'h079, 9'h079, 9'h012,
                                9'h000, 9'h000, 9'h001, 9'h000, 9'h001};
  logic [15:0] INIT_SEQ [11] = '{16'h1E00, 16'h0017, 16'h0217,
                                 16'h0479, 16'h0679, 16'h0812,
                                 16'h0A00, 16'h0C00, 16'h0E01,
                                 16'h1000, 16'h1201};
  logic [8:0] m [10];

  typedef struct {
    logic [31:0] w;
    int          n;
    int          e_wr;
    int          e_fe;
    int          e_ae;
    logic [7:0]  e_cnt;
    int          e_idx;
    logic [8:0]  e_val;
  } vec_t;

  vec_t tbl [6];

  function automatic logic [89:0] mflat();
    logic [89:0] f;
    for (int i = 0; i < 10; i++) f[i*9 +: 9] = m[i];
    return f;
  endfunction

  function automatic logic [89:0] arr_flat(input logic [8:0] a [10]);
    logic [89:0] f;
    for (int i = 0; i < 10; i++) f[i*9 +: 9] = a[i];
    return f;
  endfunction

  task automatic chk(input string nm, input logic [89:0] act,
                     input logic [89:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model(input logic [31:0] w, input int n);
    logic [6:0] a;
    a = w[15:9];
    if (n == 16) begin
      if (a < 7'd10) m[a] = w[8:0];
      else if (a == 7'h0F) m = DEF;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    csb = 1'b1;
    sclk = 1'b0;
    sdin = 1'b0;
    repeat (4) @(negedge clk_50M);
    rst = 1'b0;
    repeat (4) @(negedge clk_50M);
    m = DEF;
  endtask

  task automatic send_bits(input logic [31:0] w, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      sdin = w[i];
      repeat (HALF) @(negedge clk_50M);
      sclk = 1'b1;
      repeat (HALF) @(negedge clk_50M);
      sclk = 1'b0;
    end
    repeat (HALF) @(negedge clk_50M);
  endtask

  task automatic open_frame();
    @(negedge clk_50M);
    csb = 1'b0;
    repeat (4) @(negedge clk_50M);
  endtask

  task automatic send(input logic [31:0] w, input int n);
    open_frame();
    send_bits(w, n);
    csb = 1'b1;
    repeat (12) @(negedge clk_50M);
  endtask

  int b_wr, b_fe, b_ae, first;

  task automatic snap();
    b_wr = n_wr;
    b_fe = n_fe;
    b_ae = n_ae;
  endtask

  initial begin
    tbl[0] = '{32'h0C00, 16, 1, 0, 0, 8'd1, 6, 9'h000};
    tbl[1] = '{32'h1E00, 16, 1, 0, 0, 8'd2, 6, 9'h09F};
    tbl[2] = '{32'h1400, 16, 0, 0, 1, 8'd2, 0, 9'h097};
    tbl[3] = '{32'h0812, 15, 0, 1, 0, 8'd2, 4, 9'h00A};
    tbl[4] = '{32'h10812, 17, 0, 1, 0, 8'd2, 4, 9'h00A};
    tbl[5] = '{32'h0A05, 16, 1, 0, 0, 8'd3, 5, 9'h005};

    do_reset();
    chk("rst_strobe", 90'(wr_strobe), 90'(0));
    chk("rst_addr", 90'(wr_addr), 90'(0));
    chk("rst_data", 90'(wr_data), 90'(0));
    chk("rst_cnt", 90'(frame_cnt), 90'(0));
    chk("rst_busy", 90'(busy), 90'(0));
    chk("rst_ferr", 90'(frame_err), 90'(0));
    chk("rst_aerr", 90'(addr_err), 90'(0));
    chk("rst_regs", regs_flat, arr_flat(DEF));

    // first-frame latency from the csb rise at the pin
    open_frame();
    send_bits(32'h0812, 16);
    chk("busy_in_frame", 90'(busy), 90'(1));
    csb = 1'b1;
    first = 0;
    @(posedge clk_50M);
    for (int k = 1; k <= LAT + 2; k++) begin
      @(posedge clk_50M);
      #1;
      if (wr_strobe && first == 0) first = k;
    end
    chk("strobe_latency", 90'(first), 90'(LAT));
    repeat (8) @(negedge clk_50M);
    chk("lat_wr_addr", 90'(wr_addr), 90'(4));
    chk("lat_wr_data", 90'(wr_data), 90'(9'h012));
    chk("lat_r4", 90'(regs_flat[4*9 +: 9]), 90'(9'h012));
    chk("lat_cnt", 90'(frame_cnt), 90'(1));
    chk("lat_busy_off", 90'(busy), 90'(0));

    do_reset();
    for (int t = 0; t < 6; t++) begin
      snap();
      send(tbl[t].w, tbl[t].n);
      model(tbl[t].w, tbl[t].n);
      chk($sformatf("tbl%0d_wr", t), 90'(n_wr - b_wr), 90'(tbl[t].e_wr));
      chk($sformatf("tbl%0d_ferr", t), 90'(n_fe - b_fe), 90'(tbl[t].e_fe));
      chk($sformatf("tbl%0d_aerr", t), 90'(n_ae - b_ae), 90'(tbl[t].e_ae));
      chk($sformatf("tbl%0d_cnt", t), 90'(frame_cnt), 90'(tbl[t].e_cnt));
      chk($sformatf("tbl%0d_reg", t),
          90'(regs_flat[tbl[t].e_idx*9 +: 9]), 90'(tbl[t].e_val));
      chk($sformatf("tbl%0d_flat", t), regs_flat, mflat());
    end

    // sclk rise coincident with csb rise must not count as a bit
    snap();
    open_frame();
    send_bits(32'h0E01, 16);
    sclk = 1'b1;
    csb = 1'b1;
    repeat (12) @(negedge clk_50M);
    sclk = 1'b0;
    repeat (HALF) @(negedge clk_50M);
    model(32'h0E01, 16);
    chk("race_wr", 90'(n_wr - b_wr), 90'(1));
    chk("race_ferr", 90'(n_fe - b_fe), 90'(0));
    chk("race_r7", 90'(regs_flat[7*9 +: 9]), 90'(9'h001));
    chk("race_cnt", 90'(frame_cnt), 90'(4));

    // back-to-back frames, second csb fall lands right after the close
    snap();
    open_frame();
    send_bits(32'h1001, 16);
    csb = 1'b1;
    repeat (GAP) @(negedge clk_50M);
    csb = 1'b0;
    repeat (4) @(negedge clk_50M);
    send_bits(32'h1201, 16);
    csb = 1'b1;
    repeat (12) @(negedge clk_50M);
    model(32'h1001, 16);
    model(32'h1201, 16);
    chk("b2b_wr", 90'(n_wr - b_wr), 90'(2));
    chk("b2b_ferr", 90'(n_fe - b_fe), 90'(0));
    chk("b2b_cnt", 90'(frame_cnt), 90'(6));
    chk("b2b_flat", regs_flat, mflat());

    // sclk activity with csb high
    snap();
    for (int k = 0; k < 3; k++) begin
      sdin = 1'b1;
      sclk = 1'b1;
      repeat (HALF) @(negedge clk_50M);
      sclk = 1'b0;
      repeat (HALF) @(negedge clk_50M);
    end
    repeat (8) @(negedge clk_50M);
    chk("idle_sclk_pulses", 90'((n_wr - b_wr) + (n_fe - b_fe) + (n_ae - b_ae)),
        90'(0));
    chk("idle_sclk_cnt", 90'(frame_cnt), 90'(6));

    // reset in the middle of a frame
    do_reset();
    snap();
    open_frame();
    send_bits(32'h08, 8);
    rst = 1'b1;
    csb = 1'b1;
    sclk = 1'b0;
    repeat (4) @(negedge clk_50M);
    rst = 1'b0;
    repeat (12) @(negedge clk_50M);
    chk("midrst_pulses", 90'((n_wr - b_wr) + (n_fe - b_fe) + (n_ae - b_ae)),
        90'(0));
    chk("midrst_regs", regs_flat, arr_flat(DEF));
    chk("midrst_cnt", 90'(frame_cnt), 90'(0));
    snap();
    send(32'h0812, 16);
    chk("postrst_wr", 90'(n_wr - b_wr), 90'(1));
    chk("postrst_r4", 90'(regs_flat[4*9 +: 9]), 90'(9'h012));
    chk("postrst_cnt", 90'(frame_cnt), 90'(1));

    // full init sequence
    do_reset();
    for (int k = 0; k < 11; k++) begin
      send(32'(INIT_SEQ[k]), 16);
    end
    chk("init_cnt", 90'(frame_cnt), 90'(11));
    chk("init_regs", regs_flat, arr_flat(INIT_EXP));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
